// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
// Holds the clear-sequencer state encoding and the byte-masked merge
// used both for committing writes and for the write-first read bypass.
package regfile_pkg;

    // Clear sweep sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Widest word the merge helper handles. Callers zero-extend their
    // operands into this width and truncate the result back down, which
    // keeps one helper usable for any DATA_W up to this bound.
    localparam int MERGE_W    = 512;
    localparam int MERGE_BE_W = MERGE_W / 8;

    // Byte-masked merge: byte b of the result comes from new_word when
    // be[b] is set, otherwise from old_word.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Hardware clear sequencer for the register file.
// On a clr_req pulse in IDLE it walks every entry from 0 to DEPTH-1,
// issuing one zero-write per cycle, and holds busy high for exactly
// DEPTH cycles. A reset mid-sweep aborts at once; the write for the
// entry being addressed in the reset cycle is suppressed so that only
// entries cleared on earlier edges end up zero.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // Terminal count is compared explicitly so non-power-of-2 depths
    // stop at the last real entry instead of relying on counter wrap.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);

    clr_state_t        state_reg;
    clr_state_t        state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;

    // State and sweep counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, counter advance and clear-write outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy       = 1'b0;
        clr_we     = 1'b0;
        clr_addr   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                busy   = 1'b1;
                // Reset wins over the pending zero-write of this cycle.
                clr_we = ~rst;
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: one byte-enabled write port, one
// registered read port with a valid strobe, write-first bypass and a
// hardware clear sweep. The clear sequencer takes over the write port
// while it runs; user reads and writes are ignored during the sweep.
// Addresses at or beyond DEPTH (only possible for non-power-of-2
// depths) drop writes and read back as zero with rvalid asserted.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   wbe,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              clr_req,
    output logic              busy
);

    // DEPTH always fits in one bit more than the address, so range
    // checks are done at that width without any signed/unsigned mixing.
    localparam logic [ADDR_W:0] DEPTH_VAL = (ADDR_W + 1)'(DEPTH);

    // Storage; deliberately not reset.
    logic [DATA_W-1:0] mem [DEPTH];

    // Clear sequencer interface.
    logic              clr_busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    // User access qualification.
    logic wr_in_range;
    logic rd_in_range;
    logic user_wr;
    logic user_rd;
    logic bypass_hit;

    // Shared write port after the clear/user mux.
    logic              port_we;
    logic [ADDR_W-1:0] port_addr;
    logic [DATA_W-1:0] port_wdata;
    logic [BE_W-1:0]   port_be;
    logic [DATA_W-1:0] port_old;
    logic [DATA_W-1:0] port_word;

    // Read path.
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;

    regfile_clr_seq #(
        .DEPTH (DEPTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign busy = clr_busy;

    assign wr_in_range = ({1'b0, waddr} < DEPTH_VAL);
    assign rd_in_range = ({1'b0, raddr} < DEPTH_VAL);

    // The sweep owns the array; user strobes are simply dropped.
    assign user_wr    = we & ~clr_busy & wr_in_range;
    assign user_rd    = re & ~clr_busy;
    assign bypass_hit = user_wr & (raddr == waddr);

    // Write port mux: the clear sweep overrides the user write.
    always_comb begin
        port_we    = 1'b0;
        port_addr  = waddr;
        port_wdata = wdata;
        port_be    = wbe;
        if (clr_we) begin
            port_we    = 1'b1;
            port_addr  = clr_addr;
            port_wdata = '0;
            port_be    = '1;
        end else if (user_wr) begin
            port_we = 1'b1;
        end
    end

    // Merged post-write word; also feeds the write-first bypass.
    always_comb begin
        port_old  = port_we ? mem[port_addr] : '0;
        port_word = DATA_W'(byte_merge(MERGE_W'(port_old),
                                       MERGE_W'(port_wdata),
                                       MERGE_BE_W'(port_be)));
    end

    // Array update from whichever source owns the write port.
    always_ff @(posedge clk) begin
        if (port_we) begin
            mem[port_addr] <= port_word;
        end
    end

    // Read word selection: zero out of range, bypass on same-address write.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = bypass_hit ? port_word : mem[raddr];
        end
    end

    // Registered read data and one-cycle valid; rdata holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= user_rd;
            if (user_rd) begin
                rdata_reg <= rd_word;
            end
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;

endmodule
